// File: rtl/reg_window_ctrl_if.sv
// Signal bundle between the window controller, the control unit, the register file and the spill stack memory.
// master is the controller's view; slave is the surrounding datapath/memory view.
interface reg_window_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              call;
    logic              ret;
    logic              busy;
    logic              done;
    logic              call_err;
    logic              ret_err;
    logic [1:0]        windowOut;
    logic [1:0]        rf_rreg;
    logic [15:0]       rf_rdata;
    logic              rf_we;
    logic [15:0]       rf_wdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        input  call, ret, rf_rdata, mem_rdata, mem_ack,
        output busy, done, call_err, ret_err, windowOut, rf_rreg,
               rf_we, rf_wdata, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output call, ret, rf_rdata, mem_rdata, mem_ack,
        input  busy, done, call_err, ret_err, windowOut, rf_rreg,
               rf_we, rf_wdata, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/reg_window_ctrl.sv
// Register window pointer owner: CALL/RET moves, spilling/filling the oldest window's base register to a memory stack.
// Optional WINCTRL_STATS_EN adds saturating spill_total/fill_total counters.
module reg_window_ctrl #(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] STACK_BASE = 16'h0F00,
    parameter int                MAX_SPILL  = 8,
    parameter int                RD_LAT     = 2
) (
    input  logic               clk,
    input  logic               rst,
    reg_window_ctrl_if.master  bus
`ifdef WINCTRL_STATS_EN
    ,
    output logic [15:0]        spill_total,
    output logic [15:0]        fill_total
`endif
);
    localparam int SPW = $clog2(MAX_SPILL + 1);
    localparam int CW  = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {IDLE, SP_RD, SP_WR, FL_RD, FL_SYNC, FL_WR} state_e;

    state_e            state_q, state_d;
    logic [1:0]        cur_q, cur_d;
    logic [2:0]        res_q, res_d;
    logic [SPW-1:0]    spill_q, spill_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [CW-1:0]     lat_q, lat_d;
    logic [15:0]       data_q, data_d;
    logic [1:0]        win_q, win_d;
    logic              done_q, done_d;
    logic              cerr_q, cerr_d;
    logic              rerr_q, rerr_d;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        res_d   = res_q;
        spill_d = spill_q;
        sp_d    = sp_q;
        lat_d   = lat_q;
        data_d  = data_q;
        done_d  = 1'b0;
        cerr_d  = cerr_q;
        rerr_d  = rerr_q;
        case (state_q)
            IDLE: begin
                if (bus.call) begin
                    if (res_q != 3'd4) begin
                        cur_d  = cur_q + 2'd1;
                        res_d  = res_q + 3'd1;
                        done_d = 1'b1;
                    end else if (spill_q == SPW'(MAX_SPILL)) begin
                        cerr_d = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        lat_d   = '0;
                        state_d = SP_RD;
                    end
                end else if (bus.ret) begin
                    if (res_q != 3'd1) begin
                        cur_d  = cur_q - 2'd1;
                        res_d  = res_q - 3'd1;
                        done_d = 1'b1;
                    end else if (spill_q == '0) begin
                        rerr_d = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        sp_d    = sp_q - ADDR_W'(1);
                        state_d = FL_RD;
                    end
                end
            end
            SP_RD: begin
                // The oldest window became visible on the edge into SP_RD; its data is valid RD_LAT edges later.
                if (lat_q == CW'(RD_LAT - 1)) begin
                    data_d  = bus.rf_rdata;
                    state_d = SP_WR;
                end else begin
                    lat_d = lat_q + CW'(1);
                end
            end
            SP_WR: begin
                if (bus.mem_ack) begin
                    sp_d    = sp_q + ADDR_W'(1);
                    spill_d = spill_q + SPW'(1);
                    cur_d   = cur_q + 2'd1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            FL_RD: begin
                if (bus.mem_ack) begin
                    data_d  = bus.mem_rdata;
                    state_d = FL_SYNC;
                end
            end
            FL_SYNC: state_d = FL_WR;
            FL_WR: begin
                cur_d   = cur_q - 2'd1;
                spill_d = spill_q - SPW'(1);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // windowOut is registered, so it is derived from where the FSM is heading
        case (state_d)
            SP_RD:          win_d = cur_d + 2'd1;
            FL_SYNC, FL_WR: win_d = cur_d - 2'd1;
            default:        win_d = cur_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            res_q   <= 3'd1;
            spill_q <= '0;
            sp_q    <= STACK_BASE;
            lat_q   <= '0;
            data_q  <= '0;
            win_q   <= '0;
            done_q  <= 1'b0;
            cerr_q  <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            res_q   <= res_d;
            spill_q <= spill_d;
            sp_q    <= sp_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
            win_q   <= win_d;
            done_q  <= done_d;
            cerr_q  <= cerr_d;
            rerr_q  <= rerr_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.call_err  = cerr_q;
    assign bus.ret_err   = rerr_q;
    assign bus.windowOut = win_q;
    assign bus.rf_rreg   = 2'd0;
    assign bus.rf_we     = (state_q == FL_WR);
    assign bus.rf_wdata  = (state_q == FL_WR) ? data_q : 16'd0;
    assign bus.mem_req   = (state_q == SP_WR) || (state_q == FL_RD);
    assign bus.mem_we    = (state_q == SP_WR);
    assign bus.mem_addr  = sp_q;
    assign bus.mem_wdata = (state_q == SP_WR) ? data_q : 16'd0;

`ifdef WINCTRL_STATS_EN
    logic [15:0] spill_tot_q, fill_tot_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            spill_tot_q <= 16'd0;
            fill_tot_q  <= 16'd0;
        end else begin
            if (state_q == SP_WR && bus.mem_ack && spill_tot_q != 16'hFFFF)
                spill_tot_q <= spill_tot_q + 16'd1;
            if (state_q == FL_WR && fill_tot_q != 16'hFFFF)
                fill_tot_q <= fill_tot_q + 16'd1;
        end
    end

    assign spill_total = spill_tot_q;
    assign fill_total  = fill_tot_q;
`endif
endmodule

// File: tb/tb_reg_window_ctrl.sv
// Randomized self-checking bench for reg_window_ctrl against a residency-count + LIFO-stack reference model.
module tb_reg_window_ctrl;
    localparam logic [15:0] BASE = 16'h0F00;
    localparam int          MAXS = 8;
    localparam int          RDL  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_window_ctrl_if #(.ADDR_W(16)) bus ();
`ifdef WINCTRL_STATS_EN
    logic [15:0] spill_total, fill_total;
`endif

    reg_window_ctrl dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef WINCTRL_STATS_EN
        ,
        .spill_total(spill_total),
        .fill_total(fill_total)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Environment: register file base words, delayed read port, stack memory
    logic [15:0] rf_base [4];
    logic [15:0] mem [16];
    logic [1:0]  hist [RDL];

    initial begin
        for (int i = 0; i < 4; i++) rf_base[i] = 16'($urandom);
        for (int i = 0; i < RDL; i++) hist[i] = 2'd0;
        bus.rf_rdata = rf_base[0];
        forever begin
            @(negedge clk);
            if (bus.rf_we === 1'b1) rf_base[bus.windowOut] = bus.rf_wdata;
            for (int i = RDL - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = bus.windowOut;
            bus.rf_rdata = rf_base[hist[RDL-1]];
        end
    end

    // Reference model state
    logic [1:0]  m_cur;
    int          m_res;
    logic [15:0] stack [$];
    bit          m_cerr, m_rerr;
    int          m_spills, m_fills;

    int          exp_lat, exp_mem, exp_rfwe;
    logic [1:0]  exp_win1, exp_win_end, exp_rfwin;
    logic [15:0] exp_addr, exp_wdata, exp_rfdata;

    // Observations from one operation
    int          o_lat, o_reqs, o_rfwe;
    bit          o_timeout, o_unstable, o_we, o_done_after, o_busy_after;
    logic [1:0]  o_win1, o_win_end, o_rfwin;
    logic [15:0] o_addr, o_wdata, o_rfdata;
    bit          o_cerr, o_rerr;

    task automatic model_reset();
        m_cur = 2'd0; m_res = 1; stack.delete();
        m_cerr = 0; m_rerr = 0; m_spills = 0; m_fills = 0;
    endtask

    task automatic model_step(input bit c, input bit r, input int L);
        logic [1:0] victim;
        exp_mem = 0; exp_rfwe = 0; exp_lat = 1; exp_win1 = m_cur;
        if (c) begin
            if (m_res < 4) begin
                m_cur = m_cur + 2'd1; m_res++; exp_win1 = m_cur;
            end else if (stack.size() == MAXS) begin
                m_cerr = 1;
            end else begin
                victim    = m_cur + 2'd1;
                exp_win1  = victim;
                exp_mem   = 1;
                exp_addr  = BASE + 16'(stack.size());
                exp_wdata = rf_base[victim];
                stack.push_back(exp_wdata);
                m_cur     = victim;
                exp_lat   = RDL + 1 + L;
                m_spills++;
            end
        end else if (r) begin
            if (m_res > 1) begin
                m_cur = m_cur - 2'd1; m_res--; exp_win1 = m_cur;
            end else if (stack.size() == 0) begin
                m_rerr = 1;
            end else begin
                exp_mem    = 2;
                exp_addr   = BASE + 16'(stack.size() - 1);
                exp_rfwe   = 1;
                m_cur      = m_cur - 2'd1;
                exp_rfwin  = m_cur;
                exp_rfdata = stack.pop_back();
                exp_lat    = L + 3;
                m_fills++;
            end
        end
        exp_win_end = m_cur;
    endtask

    // Issues one request, services memory with an ack L request-cycles in, records what it sees
    task automatic op(input bit c, input bit r, input int L, input bit hold);
        int n, reqn, idx;
        n = 0; reqn = 0;
        o_lat = 0; o_reqs = 0; o_rfwe = 0; o_timeout = 0; o_unstable = 0;
        @(negedge clk);
        bus.call = c; bus.ret = r;
        forever begin
            @(negedge clk);
            n++;
            if (!hold) begin bus.call = 1'b0; bus.ret = 1'b0; end
            bus.mem_ack = 1'b0;
            if (n == 1) o_win1 = bus.windowOut;
            if (bus.mem_req === 1'b1) begin
                if (reqn == 0) begin
                    o_addr = bus.mem_addr; o_we = bus.mem_we; o_wdata = bus.mem_wdata;
                end else if (o_addr !== bus.mem_addr || o_we !== bus.mem_we || (o_we && o_wdata !== bus.mem_wdata)) begin
                    o_unstable = 1;
                end
                reqn++; o_reqs++;
                if (reqn == L) begin
                    idx = int'(bus.mem_addr - BASE) & 15;
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) mem[idx] = bus.mem_wdata;
                    else bus.mem_rdata = mem[idx];
                end
            end
            if (bus.rf_we === 1'b1) begin
                o_rfwe++; o_rfwin = bus.windowOut; o_rfdata = bus.rf_wdata;
            end
            if (bus.done === 1'b1) begin
                o_lat = n; o_win_end = bus.windowOut; o_cerr = bus.call_err; o_rerr = bus.ret_err;
                break;
            end
            if (n >= 60) begin o_timeout = 1; break; end
        end
        bus.call = 1'b0; bus.ret = 1'b0; bus.mem_ack = 1'b0;
        @(negedge clk);
        o_done_after = bus.done; o_busy_after = bus.busy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bus.windowOut, bus.rf_rreg, bus.busy, bus.done, bus.call_err, bus.ret_err, bus.rf_we, bus.mem_req, bus.mem_we} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got win=%0d rreg=%0d busy=%b done=%b cerr=%b rerr=%b rfwe=%b req=%b we=%b, want all 0",
                     bus.windowOut, bus.rf_rreg, bus.busy, bus.done, bus.call_err, bus.ret_err, bus.rf_we, bus.mem_req, bus.mem_we);
        end
        n_cmp++;
        if (bus.mem_addr !== BASE || bus.mem_wdata !== 16'd0 || bus.rf_wdata !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_data: addr=%h wdata=%h rf_wdata=%h, want %h 0000 0000", bus.mem_addr, bus.mem_wdata, bus.rf_wdata, BASE);
        end
    endtask

    task automatic test_calls();
        for (int i = 0; i < 3; i++) begin
            model_step(1, 0, 1);
            op(1, 0, 1, 0);
            n_cmp++;
            if (o_timeout || o_lat != 1 || o_win_end !== exp_win_end || o_reqs != 0 || o_busy_after !== 1'b0) begin
                n_bad++;
                $display("FAIL call_%0d: lat=%0d win=%0d reqs=%0d busy=%b to=%b, want lat=1 win=%0d reqs=0 busy=0",
                         i, o_lat, o_win_end, o_reqs, o_busy_after, o_timeout, exp_win_end);
            end
        end
    endtask

    task automatic test_spill();
        rf_base[0] = 16'hBEEF;
        repeat (RDL + 1) @(negedge clk);
        model_step(1, 0, 3);
        op(1, 0, 3, 1);
        n_cmp++;
        if (o_win1 !== 2'd0 || o_addr !== 16'h0F00 || o_wdata !== 16'hBEEF || o_we !== 1'b1) begin
            n_bad++;
            $display("FAIL spill_write: win=%0d addr=%h data=%h we=%b, want win=0 addr=0f00 data=beef we=1", o_win1, o_addr, o_wdata, o_we);
        end
        n_cmp++;
        if (o_timeout || o_lat != exp_lat || o_win_end !== 2'd0 || o_reqs != 3 || o_unstable || o_done_after !== 1'b0) begin
            n_bad++;
            $display("FAIL spill_timing: lat=%0d win=%0d reqs=%0d unstable=%b done_after=%b, want lat=%0d win=0 reqs=3 unstable=0 done_after=0",
                     o_lat, o_win_end, o_reqs, o_unstable, o_done_after, exp_lat);
        end
    endtask

    task automatic test_rets_fill();
        for (int i = 0; i < 4; i++) begin
            model_step(0, 1, 2);
            op(0, 1, 2, 0);
            n_cmp++;
            if (o_timeout || o_lat != exp_lat || o_win_end !== exp_win_end || o_rfwe != exp_rfwe) begin
                n_bad++;
                $display("FAIL ret_%0d: lat=%0d win=%0d rfwe=%0d, want lat=%0d win=%0d rfwe=%0d",
                         i, o_lat, o_win_end, o_rfwe, exp_lat, exp_win_end, exp_rfwe);
            end
        end
        n_cmp++;
        if (o_addr !== 16'h0F00 || o_we !== 1'b0 || o_rfwin !== exp_rfwin || o_rfdata !== 16'hBEEF || o_reqs != 2) begin
            n_bad++;
            $display("FAIL fill: addr=%h we=%b rfwin=%0d rfdata=%h reqs=%0d, want addr=0f00 we=0 rfwin=%0d rfdata=beef reqs=2",
                     o_addr, o_we, o_rfwin, o_rfdata, o_reqs, exp_rfwin);
        end
    endtask

    task automatic test_ret_err();
        model_step(0, 1, 1);
        op(0, 1, 1, 0);
        n_cmp++;
        if (o_timeout || o_lat != 1 || o_rerr !== 1'b1 || o_cerr !== 1'b0 || o_win_end !== 2'd0 || o_reqs != 0) begin
            n_bad++;
            $display("FAIL ret_err: lat=%0d rerr=%b cerr=%b win=%0d reqs=%0d, want lat=1 rerr=1 cerr=0 win=0 reqs=0",
                     o_lat, o_rerr, o_cerr, o_win_end, o_reqs);
        end
    endtask

    task automatic test_call_err();
        int L;
        for (int i = 0; i < 3 + MAXS; i++) begin
            L = $urandom_range(1, 3);
            model_step(1, 0, L);
            op(1, 0, L, 0);
        end
        n_cmp++;
        if (o_addr !== BASE + 16'(MAXS - 1) || o_win_end !== exp_win_end || o_lat != exp_lat) begin
            n_bad++;
            $display("FAIL last_spill: addr=%h win=%0d lat=%0d, want addr=%h win=%0d lat=%0d",
                     o_addr, o_win_end, o_lat, BASE + 16'(MAXS - 1), exp_win_end, exp_lat);
        end
        model_step(1, 0, 1);
        op(1, 0, 1, 0);
        n_cmp++;
        if (o_timeout || o_lat != 1 || o_cerr !== 1'b1 || o_win_end !== exp_win_end || o_reqs != 0) begin
            n_bad++;
            $display("FAIL call_err: lat=%0d cerr=%b win=%0d reqs=%0d, want lat=1 cerr=1 win=%0d reqs=0",
                     o_lat, o_cerr, o_win_end, o_reqs, exp_win_end);
        end
        for (int i = 0; i < 4; i++) begin
            model_step(0, 1, 1);
            op(0, 1, 1, 0);
        end
        n_cmp++;
        if (o_addr !== BASE + 16'(MAXS - 1) || o_rfdata !== exp_rfdata || o_win_end !== exp_win_end) begin
            n_bad++;
            $display("FAIL top_fill: addr=%h rfdata=%h win=%0d, want addr=%h rfdata=%h win=%0d",
                     o_addr, o_rfdata, o_win_end, BASE + 16'(MAXS - 1), exp_rfdata, exp_win_end);
        end
    endtask

    task automatic test_rst_abort();
        int n;
        for (int i = 0; i < 3; i++) begin
            model_step(1, 0, 1);
            op(1, 0, 1, 0);
        end
        @(negedge clk);
        bus.call = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            bus.call = 1'b0;
            n++;
        end while (bus.mem_req !== 1'b1 && n < 20);
        n_cmp++;
        if (bus.mem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_setup: mem_req=%b, want 1 within 20 cycles", bus.mem_req);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.windowOut, bus.busy, bus.done, bus.mem_req, bus.rf_we, bus.mem_we, bus.call_err, bus.ret_err} !== 9'd0 ||
            bus.mem_addr !== BASE || bus.mem_wdata !== 16'd0) begin
            n_bad++;
            $display("FAIL abort_reset: win=%0d busy=%b done=%b req=%b rfwe=%b addr=%h, want 0 0 0 0 0 %h",
                     bus.windowOut, bus.busy, bus.done, bus.mem_req, bus.rf_we, bus.mem_addr, BASE);
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_done: done=%b busy=%b, want 0 0", bus.done, bus.busy);
        end
        model_step(1, 0, 1);
        op(1, 0, 1, 0);
        n_cmp++;
        if (o_timeout || o_lat != 1 || o_win_end !== 2'd1 || o_reqs != 0) begin
            n_bad++;
            $display("FAIL abort_recall: lat=%0d win=%0d reqs=%0d, want lat=1 win=1 reqs=0", o_lat, o_win_end, o_reqs);
        end
    endtask

    task automatic test_random();
        bit c, r, hold;
        int L;
        for (int i = 0; i < 120; i++) begin
            c    = 1'($urandom_range(0, 1));
            r    = (!c) ? 1'b1 : 1'($urandom_range(0, 1));
            L    = $urandom_range(1, 4);
            hold = 1'($urandom_range(0, 1));
            model_step(c, r, L);
            op(c, r, L, hold);
            n_cmp++;
            if (o_timeout || o_lat != exp_lat || o_win1 !== exp_win1 || o_win_end !== exp_win_end ||
                o_cerr !== m_cerr || o_rerr !== m_rerr || o_rfwe != exp_rfwe || o_done_after !== 1'b0 ||
                o_reqs != ((exp_mem != 0) ? L : 0) || o_unstable) begin
                n_bad++;
                $display("FAIL rand_%0d_ctrl: c=%b r=%b lat=%0d win1=%0d win=%0d cerr=%b rerr=%b rfwe=%0d reqs=%0d, want lat=%0d win1=%0d win=%0d cerr=%b rerr=%b rfwe=%0d",
                         i, c, r, o_lat, o_win1, o_win_end, o_cerr, o_rerr, o_rfwe, o_reqs,
                         exp_lat, exp_win1, exp_win_end, m_cerr, m_rerr, exp_rfwe);
            end
            if (exp_mem != 0) begin
                n_cmp++;
                if (o_addr !== exp_addr || o_we !== (exp_mem == 1) ||
                    (exp_mem == 1 && o_wdata !== exp_wdata) ||
                    (exp_mem == 2 && (o_rfdata !== exp_rfdata || o_rfwin !== exp_rfwin))) begin
                    n_bad++;
                    $display("FAIL rand_%0d_data: addr=%h we=%b wdata=%h rfdata=%h rfwin=%0d, want addr=%h kind=%0d wdata=%h rfdata=%h rfwin=%0d",
                             i, o_addr, o_we, o_wdata, o_rfdata, o_rfwin, exp_addr, exp_mem, exp_wdata, exp_rfdata, exp_rfwin);
                end
            end
        end
`ifdef WINCTRL_STATS_EN
        n_cmp++;
        if (spill_total !== 16'(m_spills) || fill_total !== 16'(m_fills)) begin
            n_bad++;
            $display("FAIL stats: spill_total=%0d fill_total=%0d, want %0d %0d", spill_total, fill_total, m_spills, m_fills);
        end
`endif
    endtask

    initial begin
        bus.call = 1'b0; bus.ret = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = 16'd0;
        for (int i = 0; i < 16; i++) mem[i] = 16'd0;
        model_reset();
        do_reset();
        test_reset();
        test_calls();
        test_spill();
        test_rets_fill();
        do_reset();
        test_ret_err();
        do_reset();
        test_call_err();
        do_reset();
        test_rst_abort();
        do_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
